// File: rtl/microseq_controller.sv
// Microprogram sequencer: picks the next control-store address each cycle from
// dispatch, increment, jump, conditional, MOC-wait and call/return sources.
module microseq_controller #(
    parameter int unsigned           ADDR_W      = 7,
    parameter int unsigned           STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]     RESET_STATE = 7'd0,
    parameter logic [ADDR_W-1:0]     FETCH_STATE = 7'd1,
    parameter logic [ADDR_W-1:0]     ABORT_STATE = 7'd91,
    parameter int unsigned           MOC_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] enc_in,
    input  logic [2:0]        ns_sel,
    input  logic [ADDR_W-1:0] cr_addr,
    input  logic              cond_true,
    input  logic              moc,
    input  logic              hold,
    output logic [ADDR_W-1:0] state_out,
    output logic              waiting,
    output logic              stack_ovf,
    output logic              stack_unf,
    output logic              moc_to
);

    localparam int unsigned CNT_W = $clog2(MOC_TIMEOUT + 1);
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        NS_DISPATCH  = 3'b000,
        NS_INC       = 3'b001,
        NS_JUMP      = 3'b010,
        NS_CJUMP     = 3'b011,
        NS_MOCWAIT   = 3'b100,
        NS_CDISPATCH = 3'b101,
        NS_CALL      = 3'b110,
        NS_RETURN    = 3'b111
    } ns_mode_e;

    logic [ADDR_W-1:0] state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              to_q, to_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    ns_mode_e          mode;
    logic [ADDR_W-1:0] inc_addr;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              push_en;
    logic              stack_full;
    logic              stack_empty;

    assign mode        = ns_mode_e'(ns_sel);
    assign inc_addr    = state_q + ADDR_W'(1);
    assign push_idx    = IDX_W'(sp_q);
    assign top_idx     = IDX_W'(sp_q - SP_W'(1));
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    // Next-state logic ignores hold; the register stage applies the freeze.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        cnt_d   = '0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        to_d    = to_q;
        push_en = 1'b0;
        case (mode)
            NS_DISPATCH:  state_d = enc_in;
            NS_INC:       state_d = inc_addr;
            NS_JUMP:      state_d = cr_addr;
            NS_CJUMP:     state_d = cond_true ? cr_addr : inc_addr;
            NS_MOCWAIT: begin
                // A completing MOC wins over a timeout in the same cycle.
                if (moc) begin
                    state_d = inc_addr;
                end else if (cnt_q == CNT_W'(MOC_TIMEOUT - 1)) begin
                    state_d = ABORT_STATE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NS_CDISPATCH: state_d = cond_true ? enc_in : FETCH_STATE;
            NS_CALL: begin
                state_d = cr_addr;
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                end
            end
            NS_RETURN: begin
                if (stack_empty) begin
                    state_d = FETCH_STATE;
                    unf_d   = 1'b1;
                end else begin
                    state_d = stack_q[top_idx];
                    sp_d    = sp_q - SP_W'(1);
                end
            end
            default:      state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            sp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else if (!hold) begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            to_q    <= to_d;
        end
    end

    // Stack storage has no reset; only the pointer defines valid entries.
    always_ff @(posedge clk) begin
        if (push_en && !hold && !reset) begin
            stack_q[push_idx] <= inc_addr;
        end
    end

    assign state_out = state_q;
    assign waiting   = (mode == NS_MOCWAIT) && !moc && !hold;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
    assign moc_to    = to_q;

endmodule
